// File: rtl/add_sub_accum.sv
// Signed add/subtract/accumulate unit with a valid/ready handshake and a registered result and flags.
// Optional compile-time feature: define ADD_SUB_SAT_EN to saturate the result and the accumulator on overflow.
module add_sub_accum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             a_d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, result_reg;
  logic [1:0]       mode_reg;
  logic             carry_reg, overflow_reg, a_d_reg;

  logic             accept;
  logic             is_sub;
  logic [WIDTH-1:0] lhs, rhs, rhs_eff, res_final;
  logic [WIDTH:0]   sum_full;
  logic             carry_calc, ovf_calc;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == HOLD);
  assign accept    = in_valid && (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is x + ~y + 1; the carry-in doubles as the subtract select.
  always_comb begin
    is_sub   = mode_reg[0];
    lhs      = mode_reg[1] ? acc_reg : a_reg;
    rhs      = mode_reg[1] ? a_reg : b_reg;
    rhs_eff  = is_sub ? ~rhs : rhs;
    sum_full = {1'b0, lhs} + {1'b0, rhs_eff} + {{WIDTH{1'b0}}, is_sub};
    carry_calc = sum_full[WIDTH] ^ is_sub;
    // Same effective operand signs with a result sign flip covers both add and subtract.
    ovf_calc = (lhs[WIDTH-1] == rhs_eff[WIDTH-1]) && (sum_full[WIDTH-1] != lhs[WIDTH-1]);
`ifdef ADD_SUB_SAT_EN
    if (ovf_calc) begin
      res_final = lhs[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_final = sum_full[WIDTH-1:0];
    end
`else
    res_final = sum_full[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= 2'b00;
      a_d_reg  <= 1'b1;
    end else if (accept) begin
      a_reg    <= a;
      b_reg    <= b;
      mode_reg <= mode;
      a_d_reg  <= ~mode[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (state_reg == CALC) begin
      result_reg   <= res_final;
      carry_reg    <= carry_calc;
      overflow_reg <= ovf_calc;
    end
  end

  // A clear landing on an accumulate CALC still lets the result use the old value, then wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if ((state_reg == CALC) && mode_reg[1]) begin
      acc_reg <= res_final;
    end
  end

  assign result   = result_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
  assign a_d      = a_d_reg;

endmodule

// File: tb/tb_add_sub_accum.sv
// Scoreboard bench for add_sub_accum: stimulus pushes expected results, a monitor pops on output.
module tb_add_sub_accum;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         clr;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         a_d;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    logic         ad;
  } exp_t;

  exp_t   exp_q[$];
  int     acc_q[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     hold_low = 1'b0;
  longint acc_model = 0;

  add_sub_accum #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry),
    .overflow(overflow), .a_d(a_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic at W bits.
  function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv);
    longint mm, half, l, r, sl, sr, full, res;
    exp_t e;
    mm   = longint'(1) << W;
    half = mm / 2;
    l    = m[1] ? acc_model : longint'(av);
    r    = m[1] ? longint'(av) : longint'(bv);
    sl   = (l >= half) ? l - mm : l;
    sr   = (r >= half) ? r - mm : r;
    if (m[0]) begin
      e.c  = (l < r);
      full = sl - sr;
    end else begin
      e.c  = ((l + r) >= mm);
      full = sl + sr;
    end
    e.ov = (full >= half) || (full < -half);
    res  = ((full % mm) + mm) % mm;
`ifdef ADD_SUB_SAT_EN
    if (e.ov) res = (full > 0) ? half - 1 : half;
`endif
    e.res = res[W-1:0];
    e.ad  = !m[0];
    if (m[1]) acc_model = res;
    return e;
  endfunction

  // clr_opt: 0 none, 1 clear while idle before the op, 2 clear during the op's CALC cycle.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv, input int clr_opt);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        tests++; fails++;
        $display("FAIL wait_in_ready: got in_ready=0, expected 1 within 100 cycles");
        return;
      end
    end
    if (clr_opt == 1) begin
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      acc_model = 0;
    end
    in_valid = 1'b1; mode = m; a = av; b = bv;
    e = model(m, av, bv);
    @(posedge clk); #1;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
    if (clr_opt == 2) begin
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      acc_model = 0;
    end
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) begin
        tests++; fails++;
        $display("FAIL wait_out_valid: got out_valid=0, expected 1 within 20 cycles");
        return;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every HOLD cycle compares against the queue head; pops on release.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_out_valid: got out_valid=1, expected no pending op");
        end else begin
          if (!prev) check("latency", 64'(cyc - acc_q[0]), 64'd1);
          check("result", 64'(result), 64'(exp_q[0].res));
          check("carry", 64'(carry), 64'(exp_q[0].c));
          check("overflow", 64'(overflow), 64'(exp_q[0].ov));
          check("a_d", 64'(a_d), 64'(exp_q[0].ad));
          check("in_ready_busy", 64'(in_ready), 64'd0);
          if (out_ready) begin
            $display("[TB] op done: result=%0h carry=%0b ovf=%0b a_d=%0b", result, carry, overflow, a_d);
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev = out_valid;
    end
  end

  initial begin
    int n;
    int c;
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; mode = 2'b00; a = '0; b = '0;
    #23;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_a_d", 64'(a_d), 64'd1);
    @(posedge clk); #1;

    issue(2'b00, 8'd100, 8'd27, 0);
    issue(2'b00, 8'd100, 8'd28, 0);
    issue(2'b01, 8'd5, 8'd7, 0);
    issue(2'b01, 8'h80, 8'd1, 0);
    issue(2'b10, 8'd10, 8'd0, 1);
    issue(2'b10, 8'd10, 8'd0, 0);
    issue(2'b10, 8'd10, 8'd0, 0);
    issue(2'b11, 8'd40, 8'd0, 0);
    issue(2'b10, 8'd1, 8'd0, 2);
    issue(2'b10, 8'd1, 8'd0, 0);

    // Held result with in_valid pulsing; extra accepts would show up as spurious outputs.
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    hold_low = 1'b1;
    issue(2'b00, 8'd3, 8'd4, 0);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; a = 8'd9; b = 8'd9; mode = 2'b00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    hold_low = 1'b0;
    n = 0;
    while (out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("idle_after_release", 64'(in_ready), 64'd1);

    // Asynchronous reset while holding an accumulate result.
    hold_low = 1'b1;
    issue(2'b10, 8'd50, 8'd0, 0);
    wait_out_valid();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_overflow", 64'(overflow), 64'd0);
    exp_q.delete();
    acc_q.delete();
    acc_model = 0;
    hold_low = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_a_d", 64'(a_d), 64'd1);
    @(posedge clk); #1;
    issue(2'b10, 8'd1, 8'd0, 0);

    for (int i = 0; i < 150; i++) begin
      c = $urandom_range(0, 5);
      issue(2'($urandom), W'($urandom), W'($urandom), (c == 4) ? 1 : ((c == 5) ? 2 : 0));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending ops, expected 0", exp_q.size());
    end
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/add_sub_accum.md
# add_sub_accum

Parametrised sum/difference unit, successor to the single-bit add/subtract mode FSM. Accepts operand pairs over a valid/ready handshake and performs signed add, subtract, accumulate-add or accumulate-subtract at WIDTH bits. Returns a registered result with carry/borrow and overflow flags. Sits between the operand source (switch/register front end) and the display/result consumer in the Sum_Difference datapath.

## Interface
- WIDTH, default 8: operand, result and accumulator width in bits (two's complement), minimum 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/mode presented.
- in_ready  out  1  block can accept; high only in IDLE.
- mode  in  2  00 ADD (a+b), 01 SUB (a-b), 10 ACC_ADD (acc+a), 11 ACC_SUB (acc-a).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored in ACC modes.
- clr  in  1  synchronous accumulator clear, honoured in any state.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- carry  out  1  add: carry out of bit WIDTH-1; sub: borrow (unsigned minuend < subtrahend).
- overflow  out  1  signed overflow of the operation.
- a_d  out  1  1 = last accepted op was add-type, 0 = subtract-type.

## Operation
- FSM states: IDLE, CALC, HOLD.
  - IDLE: in_ready=1. On in_valid: latch a, b and mode; go to CALC.
  - CALC: compute from latched operands. Left operand is a (ADD/SUB) or acc (ACC modes). Register result, carry, overflow. ACC modes also write result to acc. Go to HOLD.
  - HOLD: out_valid=1. On out_ready go to IDLE; otherwise stay.
- Subtraction is computed as x + ~y + 1. Borrow = NOT of the adder carry-out.
- Overflow rule: add, operands same sign and result sign differs; sub, operands differ in sign and result sign differs from the left operand.
- a_d updates on the accept edge from mode[0]: 0 gives a_d=1, 1 gives a_d=0.
- clr: acc <= 0 at the next edge. If it coincides with an ACC-mode CALC:
  - result and flags still use the old acc;
  - acc ends at 0 (clr wins).
- Reset values: state IDLE, acc 0, result 0, carry 0, overflow 0, out_valid 0, a_d 1. in_ready goes to 1 as soon as reset is released.

## Timing
- Accept edge = the edge where in_valid && in_ready.
- CALC lasts exactly one cycle. out_valid rises after the edge following the accept edge (one-cycle latency).
- result, carry, overflow and a_d are stable while out_valid=1 and out_ready=0.
- Release edge = the edge where out_valid && out_ready. out_valid falls and in_ready rises at that edge. The next operand can be accepted no earlier than the following edge.
- Peak throughput: one op per 3 cycles.
- in_valid while not in IDLE is ignored: no latch, no state change.
- Reset asserted mid-operation aborts immediately. out_valid drops asynchronously and acc clears; the in-flight op is lost.
- All arithmetic wraps modulo 2^WIDTH unless saturation is compiled in.

## Configuration
- ADD_SUB_SAT_EN defined: on overflow, result (and acc in ACC modes) saturates to 2^(WIDTH-1)-1 for positive overflow or -2^(WIDTH-1) for negative overflow. overflow and carry still report the unsaturated operation.
- ADD_SUB_SAT_EN undefined: result wraps; no saturation logic is present.

## Test plan
- WIDTH=8, ADD a=100 b=27 -> result 127 (0x7F), carry 0, overflow 0, a_d 1; out_valid exactly one cycle after the accept edge.
- ADD a=100 b=28 -> result 0x80, overflow 1, carry 0. With ADD_SUB_SAT_EN: result 0x7F, overflow 1.
- SUB a=5 b=7 -> result 0xFE, carry (borrow) 1, overflow 0, a_d 0. SUB a=0x80 b=1 -> result 0x7F, overflow 1 (with SAT_EN, 0x80).
- clr, then ACC_ADD a=10 three times -> results 10, 20, 30. Then ACC_SUB a=40 -> 0xF6 (-10). clr during the CALC of a fifth ACC_ADD a=1 -> result 0xF7, next ACC_ADD a=1 -> 1.
- ADD 3+4, out_ready held low 5 cycles with in_valid pulsed -> result 7 held, in_ready 0, new operands ignored. out_ready high -> IDLE the next cycle.
- rst_n low during HOLD -> out_valid 0, result 0 and acc 0 without waiting for clk. After release, in_ready 1 and a_d 1.
